// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS cook timer: keypad digits shift in from the right in load
// mode, and each timing pulse counts down one second in count mode.
module countdown_timer #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5,
    parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt,
    input  logic       enbn,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       running,
    output logic       done
);

    logic       pgt_q;
    logic       tick;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       done_q, done_d;

    logic [3:0] dec_so, dec_st, dec_mo, dec_mt;
    logic       bor_so, bor_st, bor_mo;

    assign tick    = pgt & ~pgt_q;
    assign zero    = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                     (min_ones_q == 4'd0) && (min_tens_q == 4'd0);
    assign running = enbn & ~zero;

    // One-second BCD borrow cascade from the current digits.
    always_comb begin
        dec_so = sec_ones_q;
        dec_st = sec_tens_q;
        dec_mo = min_ones_q;
        dec_mt = min_tens_q;
        bor_so = 1'b0;
        bor_st = 1'b0;
        bor_mo = 1'b0;

        if (sec_ones_q == 4'd0) begin
            dec_so = 4'd9;
            bor_so = 1'b1;
        end else begin
            dec_so = sec_ones_q - 4'd1;
        end

        if (bor_so) begin
            if (sec_tens_q == 4'd0) begin
                dec_st = SEC_TENS_MAX;
                bor_st = 1'b1;
            end else begin
                dec_st = sec_tens_q - 4'd1;
            end
        end

        if (bor_st) begin
            if (min_ones_q == 4'd0) begin
                dec_mo = 4'd9;
                bor_mo = 1'b1;
            end else begin
                dec_mo = min_ones_q - 4'd1;
            end
        end

        if (bor_mo) begin
            dec_mt = (min_tens_q == 4'd0) ? MIN_TENS_MAX : min_tens_q - 4'd1;
        end
    end

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        done_d     = 1'b0;

        if (tick) begin
            if (!enbn) begin
                if (!loadn && (D <= 4'd9)) begin
                    min_tens_d = min_ones_q;
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = D;
                end
            end else if (!zero) begin
                sec_ones_d = dec_so;
                sec_tens_d = dec_st;
                min_ones_d = dec_mo;
                min_tens_d = dec_mt;
                done_d     = (dec_so == 4'd0) && (dec_st == 4'd0) &&
                             (dec_mo == 4'd0) && (dec_mt == 4'd0);
            end
        end
    end

    // pgt_q resets high so a pulse already asserted at release is not a tick.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            pgt_q      <= 1'b1;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            pgt_q      <= pgt;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            done_q     <= done_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, directed corner sequences, and a
// randomized run against a decimal-arithmetic model of the timer.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       clearn;
    logic [3:0] D;
    logic       loadn;
    logic       pgt;
    logic       enbn;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, running, done;

    int checks = 0;
    int passed = 0;

    countdown_timer dut (
        .clk      (clk),
        .clearn   (clearn),
        .D        (D),
        .loadn    (loadn),
        .pgt      (pgt),
        .enbn     (enbn),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .zero     (zero),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    wire [15:0] digs = {min_tens, min_ones, sec_tens, sec_ones};

    typedef struct {
        logic        enbn;
        logic        loadn;
        logic [3:0]  d;
        logic [15:0] exp_digs;
        logic        exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // One pgt rising edge; returns at the negedge after the updating posedge.
    task automatic pulse();
        @(negedge clk) pgt = 1'b1;
        @(negedge clk) pgt = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        enbn  = 1'b0;
        loadn = 1'b0;
        D     = d;
        pulse();
        loadn = 1'b1;
    endtask

    task automatic load_time(input logic [15:0] t);
        for (int i = 3; i >= 0; i--) press(t[i*4 +: 4]);
    endtask

    task automatic count1();
        enbn = 1'b1;
        pulse();
    endtask

    // Decimal model: mm and ss are the two-digit fields as plain numbers.
    int  m_mm, m_ss;
    bit  m_prev, m_done;

    function automatic logic [15:0] model_digs();
        return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    initial begin
        logic [15:0] ed;
        logic        ez;
        int          v;

        vecs[0] = '{1'b0, 1'b0, 4'd1,  16'h0001, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'd3,  16'h0013, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'd0,  16'h0130, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'hC,  16'h0130, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4'd5,  16'h0130, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'd0,  16'h0129, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 4'd0,  16'h1290, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 4'd0,  16'h1289, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 4'd3,  16'h1288, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 4'd9,  16'h2889, 1'b0};

        // Reset with pgt already high: no tick after release.
        clearn = 1'b0; pgt = 1'b1; enbn = 1'b0; loadn = 1'b0; D = 4'd5;
        #1;
        check("reset_digits", digs, 16'h0000);
        check("reset_zero", zero, 1'b1);
        check("reset_running", running, 1'b0);
        repeat (2) @(negedge clk);
        clearn = 1'b1;
        repeat (5) @(negedge clk);
        check("pgt_high_no_tick", digs, 16'h0000);
        check("pgt_high_done", done, 1'b0);
        check("pgt_high_zero", zero, 1'b1);
        pgt = 1'b0; loadn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            enbn  = vecs[i].enbn;
            loadn = vecs[i].loadn;
            D     = vecs[i].d;
            pulse();
            ed = vecs[i].exp_digs;
            ez = (ed == 16'h0000);
            check($sformatf("vec%0d", i), {digs, done, zero, running},
                  {ed, vecs[i].exp_done, ez, vecs[i].enbn & ~ez});
        end
        loadn = 1'b1;

        load_time(16'h0100); count1();
        check("borrow_0100", {digs, done}, {16'h0059, 1'b0});
        load_time(16'h1000); count1();
        check("borrow_1000", {digs, done}, {16'h0959, 1'b0});
        load_time(16'h9999); count1();
        check("dec_9999", digs, 16'h9998);
        load_time(16'h9990); count1();
        check("dec_9990", digs, 16'h9989);
        load_time(16'h0060); count1();
        check("dec_0060", digs, 16'h0059);

        load_time(16'h0002); count1();
        check("to_0001", {digs, done}, {16'h0001, 1'b0});
        count1();
        check("to_0000", {digs, done, zero, running}, {16'h0000, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        check("done_one_clk", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            count1();
            check($sformatf("hold_zero%0d", i), {digs, done}, {16'h0000, 1'b0});
        end

        load_time(16'h0045); count1(); count1();
        check("count_0043", digs, 16'h0043);
        press(4'd7);
        check("resume_load", digs, 16'h0437);
        count1();
        check("resume_count", digs, 16'h0436);

        load_time(16'h0005);
        for (int i = 0; i < 4; i++) press(4'd0);
        check("load_to_zero_no_done", {digs, done}, {16'h0000, 1'b0});

        load_time(16'h0211); count1();
        check("pre_reset", digs, 16'h0210);
        @(negedge clk) pgt = 1'b1;
        #2 clearn = 1'b0;
        #1 check("async_clear", digs, 16'h0000);
        @(negedge clk) pgt = 1'b0;
        clearn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            count1();
            check($sformatf("post_clear%0d", i), {digs, done}, {16'h0000, 1'b0});
        end

        // Randomized run against the decimal model.
        @(negedge clk);
        pgt = 1'b0; enbn = 1'b0; loadn = 1'b1; D = 4'd0;
        clearn = 1'b0;
        #1 clearn = 1'b1;
        m_mm = 0; m_ss = 0; m_prev = 1'b1; m_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ez = (m_mm == 0) && (m_ss == 0);
            check($sformatf("rand%0d", i), {digs, done, zero, running},
                  {model_digs(), m_done, ez, enbn & ~ez});
            pgt   = 1'($urandom_range(0, 1));
            enbn  = ($urandom_range(0, 9) < 6);
            loadn = ($urandom_range(0, 3) == 0);
            D     = 4'($urandom_range(0, 15));
            m_done = 1'b0;
            if (pgt && !m_prev) begin
                if (!enbn) begin
                    if (!loadn && D <= 9) begin
                        v = ((m_mm * 100 + m_ss) * 10 + int'(D)) % 10000;
                        m_mm = v / 100;
                        m_ss = v % 100;
                    end
                end else if (!ez) begin
                    if (m_ss > 0) m_ss--;
                    else begin
                        m_ss = 59;
                        m_mm--;
                    end
                    m_done = (m_mm == 0) && (m_ss == 0);
                end
            end
            m_prev = pgt;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Consumer end of the keypad encoder interface: takes the BCD digit bus, the active-low load strobe and the gated timing pulse, and holds the cook time as four BCD digits MM:SS.
- Load mode (enbn=0): each key press shifts one digit in from the right.
- Count mode (enbn=1): each timing pulse decrements the time by one second, stopping at 00:00.
- Feeds the display decoders and the magnetron/door control FSM.

Parameters:
SEC_TENS_MAX, 5, value loaded into sec_tens on a borrow out of sec_ones=0 and sec_tens=0
MIN_TENS_MAX, 9, value loaded into min_tens on wrap (never reached in normal use; reserved for bounds checks)

Ports:
clk  input  1  system clock, rising edge
clearn  input  1  asynchronous active-low reset
D  input  4  BCD digit from keypad encoder
loadn  input  1  active-low key-valid strobe from encoder
pgt  input  1  timing/load pulse from encoder; level, asynchronous to nothing, sampled on clk
enbn  input  1  mode select: 0 = load (keypad entry), 1 = count
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens
zero  output  1  1 when all four digits are 0 (combinational from digit regs)
running  output  1  enbn & ~zero (combinational)
done  output  1  one-clk pulse on count-mode transition into 00:00

Behaviour:
- Reset (clearn=0, async):
  - All digits are 0, done=0.
  - Internal pgt_q is 1, so a pgt already high at reset release does not produce a tick.
  - zero=1 and running=0 follow combinationally.
- Tick detection:
  - pgt_q <= pgt every clk.
  - tick = pgt & ~pgt_q, so there is exactly one tick per pgt rising edge.
  - All digit updates occur on the clk edge at which tick=1, giving 1-clk latency from the sampled pgt rise.
- Load mode (enbn=0), on a tick:
  - If loadn=0 and D<=9, shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - The old min_tens is discarded.
  - D>9 (invalid code): no change.
  - loadn=1: no change.
  - Digit positions are not range-checked on entry; sec_tens may hold 6..9.
- Count mode (enbn=1), on a tick:
  - If zero=1: no change, done stays 0.
  - Otherwise decrement MM:SS as a BCD cascade:
    - sec_ones: if 0, it becomes 9 and borrows; else it decrements.
    - sec_tens: on borrow, if 0 it becomes SEC_TENS_MAX and borrows; else it decrements.
    - min_ones: on borrow, if 0 it becomes 9 and borrows; else it decrements.
    - min_tens: on borrow, it decrements (a borrow at 0 is unreachable because zero gates it).
  - loadn and D are ignored.
- done:
  - done=1 for exactly the clk following a count-mode decrement whose result is 00:00; otherwise 0.
  - Entering 00:00 via reset or via load-mode shifting never asserts done.
- Mode switching:
  - Digits are retained across enbn changes (pause/resume).
  - Switching to load mode and pressing keys shifts onto the current remaining time.
  - An enbn change in the same clk as a tick: the tick is interpreted by the enbn value sampled at that edge.
- Reset mid-count: digits go to 0 immediately and done is suppressed.
- No wrap below 00:00. 99:59+ entry values such as 99:99 count down correctly: 99:99→99:98, …→99:90→99:89.

Test Plan:
- Reset with pgt=1, release clearn, hold pgt high 5 clks -> digits stay 00:00, zero=1, done=0, no tick.
- enbn=0; key presses D=1,3,0 (each loadn=0 with one pgt rising edge) -> digits 01:30 after the third tick; D=4'hC press -> still 01:30.
- From 01:30, enbn=1, 1 tick -> 01:29; from 01:00, 1 tick -> 00:59; from 10:00, 1 tick -> 09:59.
- From 00:02, enbn=1, 2 ticks -> 00:01 then 00:00 with done=1 for one clk, running=0; 3 further ticks -> unchanged, done=0.
- Count 00:45 -> 00:43, set enbn=0, press D=7 -> 04:37; enbn=1, tick -> 04:36.
- Assert clearn=0 mid-count at 02:10 between clk edges -> digits 00:00 asynchronously, no done pulse after release.
